// File: rtl/fir_mac_seq_if.sv
// Sample, result, coefficient-write and status bundle for fir_mac_seq.
// The master drives samples and coefficients; the slave (the filter) returns results and status.
interface fir_mac_seq_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 3
);
  logic signed [DW-1:0] xin;
  logic                 donext;
  logic                 busy;
  logic signed [DW-1:0] yout;
  logic                 yvalid;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_din;
  logic                 overrun;
  logic                 sat;

  modport master (
    output xin, donext, coef_we, coef_addr, coef_din,
    input  busy, yout, yvalid, overrun, sat
  );

  modport slave (
    input  xin, donext, coef_we, coef_addr, coef_din,
    output busy, yout, yvalid, overrun, sat
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Time-shared single-MAC FIR with circular delay line and round/saturate; result TAPS+2 cycles after donext.
// No backpressure: a donext while busy is dropped and flagged in sticky overrun.
module fir_mac_seq #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 8,
  parameter int FRAC = 15
) (
  input  logic         clk30x,
  input  logic         rst,
  fir_mac_seq_if.slave io
);
  localparam int AW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW   = DW + CW;
  localparam int ACCW = PW + AW;
  localparam int RW   = ACCW + 1;

  localparam logic signed [RW-1:0] HALF = RW'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [RW-1:0] YMAX = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] YMIN = -YMAX - RW'(1);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t               state;
  logic signed [CW-1:0] coef  [TAPS];
  logic signed [DW-1:0] dline [TAPS];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        newest;
  logic [AW-1:0]        k;
  logic [AW-1:0]        rd_idx;
  logic signed [ACCW-1:0] acc;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   acc_rnd;
  logic signed [RW-1:0]   shifted;
  logic signed [DW-1:0]   y_sat;
  logic                   clip;
  logic signed [DW-1:0]   y_rnd;
  logic                   y_clip;
  logic                   busy;
  logic signed [DW-1:0]   yout;
  logic                   yvalid;
  logic                   overrun;
  logic                   sat;

  // Tap k reads the sample k positions older than the newest, modulo the line depth.
  always_comb begin
    rd_idx = '0;
    if (newest >= k)
      rd_idx = newest - k;
    else
      rd_idx = AW'(int'(newest) + TAPS - int'(k));
  end

  assign prod = PW'(dline[rd_idx]) * PW'(coef[k]);

  // Extra headroom bit so adding the rounding constant can never wrap.
  always_comb begin
    acc_rnd = RW'(acc) + HALF;
    shifted = acc_rnd >>> FRAC;
    clip    = 1'b0;
    y_sat   = shifted[DW-1:0];
    if (shifted > YMAX) begin
      clip  = 1'b1;
      y_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < YMIN) begin
      clip  = 1'b1;
      y_sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      newest  <= '0;
      k       <= '0;
      acc     <= '0;
      y_rnd   <= '0;
      y_clip  <= 1'b0;
      busy    <= 1'b0;
      yout    <= '0;
      yvalid  <= 1'b0;
      overrun <= 1'b0;
      sat     <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i]  <= '0;
        dline[i] <= '0;
      end
    end else begin
      yvalid <= 1'b0;
      if (io.donext && busy)
        overrun <= 1'b1;
      // Writes land only while idle, so a computation always sees a stable coefficient set.
      if (io.coef_we && !busy && int'(io.coef_addr) < TAPS)
        coef[io.coef_addr] <= io.coef_din;

      case (state)
        IDLE: begin
          if (io.donext) begin
            dline[wr_ptr] <= io.xin;
            newest        <= wr_ptr;
            wr_ptr        <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + AW'(1);
            acc           <= '0;
            k             <= '0;
            busy          <= 1'b1;
            state         <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          if (k == AW'(TAPS - 1))
            state <= ROUND;
          else
            k <= k + AW'(1);
        end
        ROUND: begin
          y_rnd  <= y_sat;
          y_clip <= clip;
          state  <= OUT;
        end
        OUT: begin
          yout   <= y_rnd;
          yvalid <= 1'b1;
          sat    <= sat | y_clip;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy    = busy;
  assign io.yout    = yout;
  assign io.yvalid  = yvalid;
  assign io.overrun = overrun;
  assign io.sat     = sat;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed-vector bench for fir_mac_seq: 8-tap Q15 instance plus a 3-tap FRAC=8 instance.
module tb_fir_mac_seq;
  logic clk30x = 1'b0;
  logic rst    = 1'b0;
  int   nvec   = 0;
  int   nerr   = 0;

  always #5 clk30x = ~clk30x;

  fir_mac_seq_if #(.DW(16), .CW(16), .AW(3)) ifa ();
  fir_mac_seq_if #(.DW(16), .CW(16), .AW(2)) ifb ();

  fir_mac_seq #(.DW(16), .CW(16), .TAPS(8), .FRAC(15)) dut_a (.clk30x(clk30x), .rst(rst), .io(ifa));
  fir_mac_seq #(.DW(16), .CW(16), .TAPS(3), .FRAC(8))  dut_b (.clk30x(clk30x), .rst(rst), .io(ifb));

  typedef struct {
    int                 cfg;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               s;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int cfg, input int x, input int y, input logic s);
    vec_t v;
    v.cfg = cfg;
    v.x   = 16'(x);
    v.y   = 16'(y);
    v.s   = s;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk30x);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk30x);
    #1;
    rst = 1'b0;
  endtask

  task automatic wr_a(input int a, input int v);
    ifa.coef_we   = 1'b1;
    ifa.coef_addr = 3'(a);
    ifa.coef_din  = 16'(v);
    @(posedge clk30x);
    #1;
    ifa.coef_we = 1'b0;
  endtask

  task automatic wr_b(input int a, input int v);
    ifb.coef_we   = 1'b1;
    ifb.coef_addr = 2'(a);
    ifb.coef_din  = 16'(v);
    @(posedge clk30x);
    #1;
    ifb.coef_we = 1'b0;
  endtask

  task automatic strobe_a(input int x);
    ifa.xin    = 16'(x);
    ifa.donext = 1'b1;
    @(posedge clk30x);
    #1;
    ifa.donext = 1'b0;
  endtask

  // Cycles are counted from the edge that accepts donext to the sample where yvalid is seen.
  task automatic sample_a(input int x, output int lat);
    int w;
    w = 0;
    while (ifa.busy && w < 40) begin
      @(posedge clk30x);
      #1;
      w++;
    end
    strobe_a(x);
    lat = 0;
    while (!ifa.yvalid && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
  endtask

  task automatic sample_b(input int x, output int lat);
    ifb.xin    = 16'(x);
    ifb.donext = 1'b1;
    @(posedge clk30x);
    #1;
    ifb.donext = 1'b0;
    lat = 0;
    while (!ifb.yvalid && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
  endtask

  task automatic load_cfg(input int cfg);
    do_reset();
    case (cfg)
      1: for (int i = 0; i < 8; i++) wr_a(i, 1024 * (i + 1));
      2: wr_a(0, 16'h4000);
      3: for (int i = 0; i < 8; i++) wr_a(i, 16'h7FFF);
      4: wr_a(0, 16'h7FFF);
      5: wr_a(0, 16'h8000);
      default: ;
    endcase
  endtask

  initial begin
    int lat;
    int c;
    logic seen;
    int bx[5];
    int by[5];

    ifa.xin = '0; ifa.donext = 1'b0; ifa.coef_we = 1'b0; ifa.coef_addr = '0; ifa.coef_din = '0;
    ifb.xin = '0; ifb.donext = 1'b0; ifb.coef_we = 1'b0; ifb.coef_addr = '0; ifb.coef_din = '0;

    // Impulse through a ramp of taps, then rounding, then saturation cases.
    add(1, 16384, 512, 1'b0);
    for (int i = 2; i <= 8; i++) add(0, 0, 512 * i, 1'b0);
    add(0, 0, 0, 1'b0);
    add(0, 0, 0, 1'b0);
    add(2, 3, 2, 1'b0);
    add(0, -3, -1, 1'b0);
    add(0, 1, 1, 1'b0);
    add(3, 32767, 32766, 1'b0);
    for (int i = 2; i <= 8; i++) add(0, 32767, 32767, 1'b1);
    add(4, -32768, -32767, 1'b0);
    add(5, -32768, 32767, 1'b1);

    do_reset();
    chk("reset yout", ifa.yout, 0);
    chk("reset yvalid", ifa.yvalid, 0);
    chk("reset busy", ifa.busy, 0);
    chk("reset overrun", ifa.overrun, 0);
    chk("reset sat", ifa.sat, 0);

    foreach (tbl[i]) begin
      if (tbl[i].cfg != 0) load_cfg(tbl[i].cfg);
      sample_a(tbl[i].x, lat);
      chk($sformatf("vec%0d latency", i), lat, 10);
      chk($sformatf("vec%0d yout", i), ifa.yout, tbl[i].y);
      chk($sformatf("vec%0d sat", i), ifa.sat, tbl[i].s);
    end

    // Overrun at cycle 3 and a blocked coefficient write at cycle 5.
    load_cfg(2);
    wr_a(1, 16'h2000);
    strobe_a(1000);
    c = 0;
    while (c < 40) begin
      c++;
      ifa.donext    = (c == 3);
      ifa.xin       = (c == 3) ? 16'sd5000 : 16'sd1000;
      ifa.coef_we   = (c == 5);
      ifa.coef_addr = '0;
      ifa.coef_din  = 16'h7FFF;
      @(posedge clk30x);
      #1;
      if (ifa.yvalid) break;
    end
    ifa.donext  = 1'b0;
    ifa.coef_we = 1'b0;
    chk("ovr latency", c, 10);
    chk("ovr yout", ifa.yout, 500);
    chk("ovr flag", ifa.overrun, 1);
    sample_a(1000, lat);
    chk("ovr followup yout", ifa.yout, 750);

    // donext on the edge where busy falls is still an overrun.
    load_cfg(2);
    strobe_a(1000);
    c = 0;
    while (c < 40) begin
      c++;
      ifa.donext = (c == 10);
      @(posedge clk30x);
      #1;
      if (ifa.yvalid) break;
    end
    ifa.donext = 1'b0;
    chk("edge ovr flag", ifa.overrun, 1);
    repeat (2) @(posedge clk30x);
    #1;
    chk("edge ovr dropped", ifa.busy, 0);

    // First legal back-to-back accept, one edge after yvalid.
    load_cfg(2);
    sample_a(1000, lat);
    strobe_a(2000);
    chk("b2b busy", ifa.busy, 1);
    chk("b2b overrun", ifa.overrun, 0);
    lat = 0;
    while (!ifa.yvalid && lat < 40) begin
      @(posedge clk30x);
      #1;
      lat++;
    end
    chk("b2b latency", lat, 10);
    chk("b2b yout", ifa.yout, 1000);

    // Asynchronous reset in the middle of a MAC sequence.
    load_cfg(2);
    sample_a(1000, lat);
    chk("pre-rst yout", ifa.yout, 500);
    strobe_a(2000);
    repeat (3) @(posedge clk30x);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst yout", ifa.yout, 0);
    chk("midrst yvalid", ifa.yvalid, 0);
    chk("midrst busy", ifa.busy, 0);
    @(posedge clk30x);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk30x);
      #1;
      if (ifa.yvalid) seen = 1'b1;
    end
    chk("midrst no yvalid", seen, 0);
    sample_a(16384, lat);
    chk("midrst coef cleared", ifa.yout, 0);
    chk("midrst impulse latency", lat, 10);

    // 3-tap, FRAC=8 instance; the 4th sample overwrites the impulse slot.
    do_reset();
    wr_b(0, 256);
    wr_b(1, 512);
    wr_b(2, -256);
    wr_b(3, 999);
    bx = '{100, 0, 0, 0, 50};
    by = '{100, 200, -100, 0, 50};
    for (int i = 0; i < 5; i++) begin
      sample_b(bx[i], lat);
      chk($sformatf("t3 s%0d latency", i), lat, 5);
      chk($sformatf("t3 s%0d yout", i), ifb.yout, by[i]);
    end
    chk("t3 sat", ifb.sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
